cipher_word_packer: RTL
=======================

Name: cipher_word_packer

Overview:
- Downstream neighbour of block_cipher_top: consumes the 8-bit encrypted_data byte stream and packs consecutive bytes into 32-bit words for the bus/FIFO interface.
- Valid/ready on both sides. A flush input emits a zero-padded partial word at end of message.
- Keeps a running count of emitted words for debug and status.

Parameters:
- DATA_W, 8: input byte width; must match block_cipher_top encrypted_data.
- BYTES_PER_WORD, 4: bytes per output word; legal values 2..8.
- CNT_W, 16: width of the emitted-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds an encrypted byte.
- in_data  in  DATA_W  encrypted byte.
- in_ready  out  1  packer can accept in_data this cycle.
- flush  in  1  single-cycle request to emit the current partial word.
- out_valid  out  1  out_data/out_bytes are valid.
- out_data  out  DATA_W*BYTES_PER_WORD  packed word; first byte received sits in bits [DATA_W-1:0].
- out_bytes  out  clog2(BYTES_PER_WORD)+1  number of valid bytes in out_data (1..BYTES_PER_WORD).
- out_ready  in  1  consumer takes the word this cycle.
- word_count  out  CNT_W  words emitted since reset; wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate) clears all state:
  - out_valid=0, out_data=0, out_bytes=0, word_count=0, fill count cnt=0, flush_pend=0.
  - in_ready reads 1 once reset is released.
- Input accept: in_valid && in_ready. The byte is written to lane cnt of the assembly register, then cnt increments.
- Output register is a single holding stage.
  - A word completes when the accepted byte takes cnt to BYTES_PER_WORD.
  - On completion the word moves to the output register on the same edge: out_valid=1, out_bytes=BYTES_PER_WORD, cnt=0, assembly register cleared.
  - Latency: the word is visible on the cycle after the completing byte.
- Output drain: out_valid && out_ready. word_count increments on this edge. out_valid falls unless a new word loads on the same edge (back-to-back allowed, no bubble).
- in_ready = !flush_pend && !(cnt==BYTES_PER_WORD-1 && out_valid && !out_ready).
  - This is combinational from out_ready and is documented as such.
  - Bytes 0..BPW-2 of the next word are always accepted while the output register is held.
- Flush:
  - Flush with cnt==0 and no byte accepted that cycle: ignored, no empty word.
  - Flush with cnt>0, or with a byte accepted the same cycle: that byte is included first, then the partial word (cnt' bytes) is emitted.
    - Unused upper lanes are zero; out_bytes = cnt'.
  - If the output register cannot load (out_valid && !out_ready), flush_pend is set. in_ready stays low until the partial word loads, then flush_pend clears.
  - A second flush while flush_pend=1 has no extra effect.
  - Flush on a byte that completes a full word: a normal full word is emitted, no extra empty word.
- out_data, out_bytes and out_valid stay stable while out_valid && !out_ready.
- word_count wraps from 2^CNT_W-1 to 0 without flag.
- Reset mid-word or mid-stall: partial data is discarded, nothing is emitted, outputs return to reset values asynchronously.

Decomposition:
- Shared package cipher_pkg:
  - CIPHER_DATA_W=8 and CIPHER_WORD_BYTES=4 constants.
  - The lane-index and byte-count width function (clog2-based).
- Optional single sub-module: cipher_out_reg, the one-entry valid/ready holding register with load/drain logic. Packing, counter and flush logic stay in the top module.

Test Plan:
- Bytes F1,22,33,44 on consecutive cycles, out_ready=1 -> one cycle after 44: out_valid=1, out_data=0x443322F1, out_bytes=4; word_count=1 after drain.
- 8 bytes 01..08 back-to-back, out_ready=0 until cycle 10 -> in_ready drops only while presenting byte 08. Words 0x04030201 then 0x08070605, order preserved, no byte lost or duplicated.
- Bytes AA,BB then flush -> out_data=0x0000BBAA, out_bytes=2. A flush with cnt=0 afterwards produces no word.
- Byte CC with flush in the same cycle while the output is stalled (out_ready=0) -> flush_pend=1 and in_ready=0. On out_ready=1, the held word drains, then 0x000000CC with out_bytes=1 is emitted, then in_ready returns to 1.
- Assert rst for one cycle after 3 bytes, asynchronously mid-cycle -> immediately out_valid=0 and word_count=0. The next 4 bytes 11,22,33,44 yield 0x44332211.
- CNT_W=4, 17 full words drained -> word_count reads 1 (wrap checked).

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared constants and helpers for the cipher datapath.
//   CIPHER_DATA_W     : width of one encrypted byte lane
//   CIPHER_WORD_BYTES : default number of lanes packed into one bus word
//   cnt_w()           : width needed to hold a lane count 0..bytes_per_word inclusive
package cipher_pkg;

    localparam int unsigned CIPHER_DATA_W     = 8;
    localparam int unsigned CIPHER_WORD_BYTES = 4;

    function automatic int unsigned cnt_w(input int unsigned bytes_per_word);
        return $clog2(bytes_per_word) + 1;
    endfunction

endpackage

// File: rtl/cipher_out_reg.sv
// One-entry valid/ready holding register for packed words.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   load_i                : capture data_i/bytes_i this edge (may coincide with a drain)
//   data_i, bytes_i       : word and its valid-byte count to capture
//   ready_i               : consumer accepts the held word this cycle
//   valid_o, data_o,
//   bytes_o               : held word; stable while valid_o && !ready_i
module cipher_out_reg #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BYTES_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [DATA_W-1:0]  data_i,
    input  logic [BYTES_W-1:0] bytes_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [DATA_W-1:0]  data_o,
    output logic [BYTES_W-1:0] bytes_o
);

    logic               valid_q;
    logic [DATA_W-1:0]  data_q;
    logic [BYTES_W-1:0] bytes_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            bytes_q <= '0;
        end else if (load_i) begin
            // Load wins over drain so back-to-back words need no bubble.
            valid_q <= 1'b1;
            data_q  <= data_i;
            bytes_q <= bytes_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign bytes_o = bytes_q;

endmodule

// File: rtl/cipher_word_packer.sv
// Packs the encrypted byte stream into bus words, first byte in the low lane.
// A flush emits the current partial word zero-padded; words drained are counted.
// Ports:
//   clk_i, rst_i                        : clock, asynchronous active-high reset
//   in_valid_i, in_data_i, in_ready_o   : byte input handshake
//   flush_i                             : single-cycle request to emit the partial word
//   out_valid_o, out_data_o,
//   out_bytes_o, out_ready_i            : word output handshake
//   word_count_o                        : words drained since reset, wraps silently
// Note: in_ready_o depends combinationally on out_ready_i.
module cipher_word_packer
    import cipher_pkg::*;
#(
    parameter int unsigned DATA_W         = CIPHER_DATA_W,
    parameter int unsigned BYTES_PER_WORD = CIPHER_WORD_BYTES,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               in_valid_i,
    input  logic [DATA_W-1:0]                  in_data_i,
    output logic                               in_ready_o,
    input  logic                               flush_i,
    output logic                               out_valid_o,
    output logic [DATA_W*BYTES_PER_WORD-1:0]   out_data_o,
    output logic [cnt_w(BYTES_PER_WORD)-1:0]   out_bytes_o,
    input  logic                               out_ready_i,
    output logic [CNT_W-1:0]                   word_count_o
);

    localparam int unsigned CW     = cnt_w(BYTES_PER_WORD);
    localparam int unsigned WORD_W = DATA_W * BYTES_PER_WORD;
    localparam logic [CW-1:0] LastLane = CW'(BYTES_PER_WORD - 1);

    logic [CW-1:0]     cnt_q, cnt_d, fill;
    logic [WORD_W-1:0] asm_q, asm_d, word;
    logic              flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]  wc_q, wc_d;
    logic              accept, complete, can_load, flush_req, load, drain;

    // Only the word-completing byte needs the output stage free; earlier lanes
    // can fill while a previous word is still held.
    assign in_ready_o = !flush_pend_q && !(cnt_q == LastLane && out_valid_o && !out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign can_load   = !out_valid_o || out_ready_i;
    assign complete   = accept && (cnt_q == LastLane);
    assign flush_req  = flush_i || flush_pend_q;
    assign drain      = out_valid_o && out_ready_i;

    always_comb begin
        word = asm_q;
        if (accept) begin
            word[int'(cnt_q)*DATA_W +: DATA_W] = in_data_i;
        end
        fill = cnt_q + CW'(accept);
        // A full word always loads: in_ready_o already guaranteed room for it.
        load = complete || (flush_req && fill != '0 && can_load);

        asm_d = load ? '0 : word;
        cnt_d = load ? '0 : fill;

        flush_pend_d = flush_pend_q;
        if (load) begin
            flush_pend_d = 1'b0;
        end else if (flush_req && fill != '0) begin
            flush_pend_d = 1'b1;
        end

        wc_d = wc_q + CNT_W'(drain);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            asm_q        <= '0;
            flush_pend_q <= 1'b0;
            wc_q         <= '0;
        end else begin
            cnt_q        <= cnt_d;
            asm_q        <= asm_d;
            flush_pend_q <= flush_pend_d;
            wc_q         <= wc_d;
        end
    end

    cipher_out_reg #(
        .DATA_W  (WORD_W),
        .BYTES_W (CW)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (load),
        .data_i  (word),
        .bytes_i (fill),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .bytes_o (out_bytes_o)
    );

    assign word_count_o = wc_q;

endmodule
